serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes diff = a - b - bin one bit per clock. It chains a single one-bit full-subtractor cell through a borrow register. It is the inverse-direction counterpart of the combinational full adder in the arithmetic library. Area-cheap arithmetic stages use it behind a simple start/done handshake.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one bit per clock,
// behind a start/done handshake. Outputs are registered and held between results.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic             ovf_q;

    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    full_subtractor u_fs (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .bi (br_q),
        .d  (bit_d),
        .bo (br_d)
    );

    // Result bits enter from the MSB side so the LSB lands in bit 0 after WIDTH shifts.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_q  <= res_d;
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    br_q   <= br_d;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at zero rather than wrapping past WIDTH-1.
                        cnt_q   <= '0;
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at start
// and compared when done pulses; latency, ignored starts and mid-op reset are probed.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    exp_t sb_q[$];
    int   n_chk;
    int   n_fail;
    int   n_done;
    int   n_pushed;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic bi);
        exp_t e;
        logic [WIDTH:0] full;
        full   = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
        e.diff = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        sb_q.push_back(model(x, y, bi));
        n_pushed++;
    endtask

    // Drive one operation, scramble inputs after acceptance, and check latency.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        int cyc;
        a = x; b = y; bin = bi; start = 1'b1;
        push(x, y, bi);
        tick();
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        chk("busy_after_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < WIDTH + 6) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, WIDTH);
        chk("busy_in_done", busy, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("diff", diff, e.diff);
                chk("bout", bout, e.bout);
                chk("ovf",  ovf,  e.ovf);
            end
        end
    end

    initial begin
        int d0;
        n_chk = 0; n_fail = 0; n_done = 0; n_pushed = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf",  ovf,  0);
        rst_n = 1'b1;
        tick();

        run_op(8'h35, 8'h12, 1'b0);
        chk("diff_held", diff, 8'h23);
        run_op(8'h12, 8'h35, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

        // Starts during SHIFT and during DONE must be dropped.
        d0 = n_done;
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        push(8'h10, 8'h01, 1'b0);
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h00; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH + 6 && !done; i++) tick();
        chk("ign_done_seen", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy_after_done", busy, 0);
        repeat (WIDTH + 3) tick();
        chk("ign_single_done", n_done - d0, 1);
        chk("ign_diff_hold", diff, 8'h0F);
        chk("ign_bout_hold", bout, 0);

        // Mid-operation reset aborts with no done.
        d0 = n_done;
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_ovf",  ovf,  0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (WIDTH + 3) tick();
        chk("abort_no_done", n_done - d0, 0);
        run_op(8'h05, 8'h03, 1'b0);
        chk("post_reset_diff", diff, 8'h02);

        repeat (2) tick();
        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", n_done, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
